ng_tmr_req: RTL and testbench

//   Receiving end of the scaler pulse outputs (F10X/F13X/F17X). Latches each one-CLK1

---
 rtl/ng_tmr_req.sv | 110 +++++++++++
 tb/tb_ng_tmr_req.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ng_tmr_req.sv
// Scaler-pulse request latch/arbiter: pulse->PEND same edge, REQ one edge later, ACK drops REQ; fixed priority 0>1>2>3.
// Optional PENDING_COUNT_EN: per-source PCW-bit pending counts instead of single flags; OVF on pulse while saturated.
module ng_tmr_req #(
  parameter int PCW = 2
) (
  input  logic       CLK1,
  input  logic       NPURST,
  input  logic       F10X,
  input  logic       F13X,
  input  logic       F17X,
  input  logic       REQ_ENAB,
  input  logic       ACK,
  input  logic       CLR_OVF,
  output logic       REQ,
  output logic [1:0] CNT_ID,
  output logic [3:0] PEND,
  output logic [3:0] OVF
);

`ifdef PENDING_COUNT_EN
  localparam int CW = PCW;
`else
  // A 1-bit saturating count behaves exactly like a pending flag; PCW has no effect here.
  localparam int CW = 1 + 0 * PCW;
`endif

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_id_q, cnt_id_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    ovf_q, ovf_d;
  logic [3:0]    pulse;
  logic [3:0]    ack_hit;
  logic [3:0]    ovf_set;
  logic [3:0]    pend;

  assign pulse = {F17X, F13X, F10X, F10X};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pend[i]    = (cnt_q[i] != '0);
      ack_hit[i] = (state_q == S_GRANT) && ACK && (cnt_id_q == 2'(i));
    end
  end

  // Pulse and ACK of the same source on one edge cancel: count unchanged, no overrun.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]   = cnt_q[i];
      ovf_set[i] = 1'b0;
      if (pulse[i] && !ack_hit[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!pulse[i] && ack_hit[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    ovf_d = (CLR_OVF ? 4'b0000 : ovf_q) | ovf_set;
  end

  always_comb begin
    state_d  = state_q;
    cnt_id_d = cnt_id_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_ENAB && (pend != 4'b0000)) begin
          state_d = S_GRANT;
          if (pend[0])      cnt_id_d = 2'd0;
          else if (pend[1]) cnt_id_d = 2'd1;
          else if (pend[2]) cnt_id_d = 2'd2;
          else              cnt_id_d = 2'd3;
        end
      end
      S_GRANT: begin
        if (ACK) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge NPURST) begin
    if (!NPURST) begin
      state_q  <= S_IDLE;
      cnt_id_q <= 2'd0;
      ovf_q    <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_id_q <= cnt_id_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign REQ    = (state_q == S_GRANT);
  assign CNT_ID = cnt_id_q;
  assign PEND   = pend;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_ng_tmr_req.sv
// Directed bench for ng_tmr_req: expected grant IDs queued at pulse time, popped as each REQ appears.
module tb_ng_tmr_req;

  logic       CLK1 = 1'b0;
  logic       NPURST = 1'b1;
  logic       F10X = 1'b0;
  logic       F13X = 1'b0;
  logic       F17X = 1'b0;
  logic       REQ_ENAB = 1'b1;
  logic       ACK = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic       REQ;
  logic [1:0] CNT_ID;
  logic [3:0] PEND;
  logic [3:0] OVF;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q [$];

  ng_tmr_req #(.PCW(2)) dut (
    .CLK1(CLK1), .NPURST(NPURST), .F10X(F10X), .F13X(F13X), .F17X(F17X),
    .REQ_ENAB(REQ_ENAB), .ACK(ACK), .CLR_OVF(CLR_OVF),
    .REQ(REQ), .CNT_ID(CNT_ID), .PEND(PEND), .OVF(OVF)
  );

  always #5 CLK1 = ~CLK1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK1);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (REQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_wait", 8'(REQ), 8'd1);
  endtask

  // Wait for a grant, compare its ID against the scoreboard, consume it; optionally pulse F17X on the ACK edge.
  task automatic serve(input logic f17);
    logic [1:0] exp_id;
    wait_req();
    n_tests++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_unexpected_grant: observed CNT_ID %0d expected no grant", CNT_ID);
    end
    if (exp_q.size() != 0) begin
      exp_id = exp_q.pop_front();
      check("cnt_id", 8'(CNT_ID), 8'(exp_id));
    end
    ACK  = 1'b1;
    F17X = f17;
    tick();
    ACK  = 1'b0;
    F17X = 1'b0;
    check("req_after_ack", 8'(REQ), 8'd0);
  endtask

  initial begin
    // Reset
    #1 NPURST = 1'b0;
    #1;
    check("rst_req", 8'(REQ), 8'd0);
    check("rst_cnt_id", 8'(CNT_ID), 8'd0);
    check("rst_pend", 8'(PEND), 8'h0);
    check("rst_ovf", 8'(OVF), 8'h0);
    tick();
    NPURST = 1'b1;
    tick();

    // 1: single F10X, two grants 0 then 1
    F10X = 1'b1; tick(); F10X = 1'b0;
    check("t1_pend", 8'(PEND), 8'h3);
    check("t1_req_not_yet", 8'(REQ), 8'd0);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    tick();
    check("t1_req_latency", 8'(REQ), 8'd1);
    serve(1'b0);
    check("t1_idle_gap", 8'(REQ), 8'd0);
    serve(1'b0);
    check("t1_pend_done", 8'(PEND), 8'h0);

    // 2: F10X and F13X together, order 0,1,2
    F10X = 1'b1; F13X = 1'b1; tick(); F10X = 1'b0; F13X = 1'b0;
    check("t2_pend", 8'(PEND), 8'h7);
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    serve(1'b0); serve(1'b0); serve(1'b0);
    check("t2_ovf", 8'(OVF), 8'h0);
    check("t2_pend_done", 8'(PEND), 8'h0);

    // 2b: F13X and F17X together, order 2,3
    F13X = 1'b1; F17X = 1'b1; tick(); F13X = 1'b0; F17X = 1'b0;
    exp_q.push_back(2'd2); exp_q.push_back(2'd3);
    serve(1'b0); serve(1'b0);
    check("t2b_pend_done", 8'(PEND), 8'h0);

    // 3: overrun on source 2
`ifdef PENDING_COUNT_EN
    for (int k = 0; k < 3; k++) begin
      F13X = 1'b1; tick(); F13X = 1'b0;
    end
    check("t3_no_ovf_queued", 8'(OVF), 8'h0);
    F13X = 1'b1; tick(); F13X = 1'b0;
    check("t3_ovf_sat", 8'(OVF), 8'h4);
    check("t3_pend", 8'(PEND), 8'h4);
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    check("t3_ovf_clr", 8'(OVF), 8'h0);
    exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    serve(1'b0); serve(1'b0); serve(1'b0);
`else
    F13X = 1'b1; tick(); F13X = 1'b0;
    F13X = 1'b1; tick(); F13X = 1'b0;
    check("t3_ovf", 8'(OVF), 8'h4);
    check("t3_pend", 8'(PEND), 8'h4);
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    check("t3_ovf_clr", 8'(OVF), 8'h0);
    check("t3_pend_kept", 8'(PEND), 8'h4);
    CLR_OVF = 1'b1; F13X = 1'b1; tick(); CLR_OVF = 1'b0; F13X = 1'b0;
    check("t3_ovf_beats_clr", 8'(OVF), 8'h4);
    CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
    check("t3_ovf_clr2", 8'(OVF), 8'h0);
    exp_q.push_back(2'd2);
    serve(1'b0);
`endif
    check("t3_pend_done", 8'(PEND), 8'h0);

    // 4: F17X on the ACK edge of source 3
    F17X = 1'b1; tick(); F17X = 1'b0;
    exp_q.push_back(2'd3);
    serve(1'b1);
    check("t4_pend_kept", 8'(PEND), 8'h8);
    check("t4_no_ovf", 8'(OVF), 8'h0);
    exp_q.push_back(2'd3);
    serve(1'b0);
    check("t4_pend_done", 8'(PEND), 8'h0);

    // 5: async reset during GRANT
    F10X = 1'b1; tick();
    tick(); F10X = 1'b0;
    check("t5_req_before", 8'(REQ), 8'd1);
`ifndef PENDING_COUNT_EN
    check("t5_ovf_before", 8'(OVF), 8'h3);
`endif
    #2 NPURST = 1'b0;
    #1;
    check("t5_req_rst", 8'(REQ), 8'd0);
    check("t5_pend_rst", 8'(PEND), 8'h0);
    check("t5_ovf_rst", 8'(OVF), 8'h0);
    check("t5_cnt_id_rst", 8'(CNT_ID), 8'd0);
    tick();
    NPURST = 1'b1;
    tick(); tick(); tick();
    check("t5_no_req_after", 8'(REQ), 8'd0);

    // 6: REQ_ENAB gating, ACK ignored in IDLE, enable drop does not withdraw
    REQ_ENAB = 1'b0;
    F10X = 1'b1; tick(); F10X = 1'b0;
    tick(); tick();
    check("t6_pend", 8'(PEND), 8'h3);
    check("t6_req_gated", 8'(REQ), 8'd0);
    ACK = 1'b1; tick(); ACK = 1'b0;
    check("t6_idle_ack_ignored", 8'(PEND), 8'h3);
    REQ_ENAB = 1'b1; tick();
    check("t6_req_enab", 8'(REQ), 8'd1);
    check("t6_cnt_id", 8'(CNT_ID), 8'd0);
    REQ_ENAB = 1'b0; tick();
    check("t6_req_held", 8'(REQ), 8'd1);
    REQ_ENAB = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1);
    serve(1'b0); serve(1'b0);
    check("t6_pend_done", 8'(PEND), 8'h0);

    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
